// File: rtl/stump_cc_unit.sv
// stump_cc_unit: Stump condition-code register, branch condition evaluation,
// interrupt shadow and saturating taken-branch counter.
module stump_cc_unit #(
   parameter bit BYPASS = 1'b0,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       flags_in,
   input  logic             flags_we,
   input  logic             save,
   input  logic             restore,
   input  logic             eval_req,
   input  logic [3:0]       cond,
   input  logic             cnt_clr,
   output logic             eval_valid,
   output logic             taken,
   output logic [3:0]       cc_out,
   output logic [CNT_W-1:0] taken_cnt
);
   logic [3:0]  shadow, ev;
   logic [15:0] tbl;
   logic        n, z, v, c, res;
   always_comb begin
      // a same-cycle restore wins the CC write, so flags_in is not forwarded then
      ev = (BYPASS && flags_we && !restore) ? flags_in : cc_out;
      {n, z, v, c} = ev;
      tbl = {z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), n, ~n, v, ~v,
             z, ~z, c, ~c, c | z, ~c & ~z, 1'b0, 1'b1};
      res = tbl[cond];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_out     <= '0;
         shadow     <= '0;
         eval_valid <= 1'b0;
         taken      <= 1'b0;
         taken_cnt  <= '0;
      end else begin
         if (restore) cc_out <= shadow;
         else if (flags_we) cc_out <= flags_in;
         if (save) shadow <= cc_out;
         eval_valid <= eval_req;
         if (eval_req) taken <= res;
         if (cnt_clr) taken_cnt <= '0;
         else if (eval_req && res && taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
      end
   end
endmodule
